// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-op encodings, MEM-stage state, and
// the EX->MEM / MEM->WB payload layouts used across the pipeline.
package pipe_pkg;

    localparam int PIPE_XLEN      = 32;
    localparam int PIPE_RADDR_W   = 5;
    localparam int PIPE_DISCARD_W = 2;

    typedef enum logic [2:0] {
        MEM_LW  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LB  = 3'b010,
        MEM_LHU = 3'b101,
        MEM_LBU = 3'b110
    } mem_op_e;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_READY = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic [PIPE_XLEN-1:0]    pc;
        logic [PIPE_XLEN-1:0]    alu_result;
        logic [PIPE_RADDR_W-1:0] dest;
        logic                    gr_we;
        logic                    is_load;
        logic                    req_sent;
        logic [2:0]              mem_op;
    } es_to_ms_t;

    typedef struct packed {
        logic [PIPE_XLEN-1:0]    pc;
        logic [PIPE_RADDR_W-1:0] dest;
        logic                    gr_we;
        logic [PIPE_XLEN-1:0]    final_result;
    } ms_to_ws_t;

endpackage

// File: rtl/load_align.sv
// Combinational sub-word load alignment with sign/zero extension.
// LW passes the word through untouched (unaligned words are not supported).
module load_align
    import pipe_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr,
    input  logic [2:0]      i_mem_op,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (mem_op_e'(i_mem_op))
            MEM_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            MEM_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            MEM_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
            MEM_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: waits on variable-latency data responses, holds load data under
// WB back-pressure, drops responses orphaned by a flush, and feeds ID forwarding.
module mem_stage_lsu
    import pipe_pkg::*;
#(
    parameter int XLEN      = PIPE_XLEN,
    parameter int RADDR_W   = PIPE_RADDR_W,
    parameter int DISCARD_W = PIPE_DISCARD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [XLEN-1:0]    es_pc,
    input  logic [XLEN-1:0]    es_alu_result,
    input  logic [RADDR_W-1:0] es_dest,
    input  logic               es_gr_we,
    input  logic               es_is_load,
    input  logic               es_req_sent,
    input  logic [2:0]         es_mem_op,
    input  logic               data_sram_data_ok,
    input  logic [XLEN-1:0]    data_sram_rdata,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic [XLEN-1:0]    ms_pc,
    output logic [RADDR_W-1:0] ms_dest,
    output logic               ms_gr_we,
    output logic [XLEN-1:0]    ms_final_result,
    output logic               ms_fwd_valid,
    output logic               ms_fwd_pending,
    output logic [RADDR_W-1:0] ms_fwd_dest,
    output logic [XLEN-1:0]    ms_fwd_data
);

    localparam logic [DISCARD_W-1:0] DISC_MAX = '1;

    ms_state_e            r_state, w_state_next;
    logic [XLEN-1:0]      r_pc, r_alu, r_hold;
    logic [RADDR_W-1:0]   r_dest;
    logic                 r_gr_we, r_is_load;
    logic [2:0]           r_mem_op;
    logic [DISCARD_W-1:0] r_discard;

    logic            w_valid, w_resp_live, w_ready_go, w_accept, w_capture;
    logic            w_disc_inc, w_disc_dec;
    logic [XLEN-1:0] w_load_src, w_load_data;

    assign w_valid     = (r_state != MS_EMPTY);
    // A response belongs to the current instruction only when no orphans are queued ahead of it.
    assign w_resp_live = data_sram_data_ok && (r_discard == '0);
    assign w_ready_go  = (r_state == MS_READY) || ((r_state == MS_WAIT) && w_resp_live);
    assign ms_allowin  = !w_valid || (w_ready_go && ws_allowin);
    assign w_accept    = es_to_ms_valid && ms_allowin && !flush;
    assign w_capture   = (r_state == MS_WAIT) && w_resp_live && !ws_allowin && !flush;

    // A flushed request still gets a response later; count it so it can be dropped.
    assign w_disc_inc = flush && (((r_state == MS_WAIT) && !w_resp_live)
                               || (es_to_ms_valid && ms_allowin && es_req_sent));
    assign w_disc_dec = data_sram_data_ok && (r_discard != '0);

    always_comb begin
        w_state_next = r_state;
        if (flush)
            w_state_next = MS_EMPTY;
        else if (ms_allowin)
            w_state_next = es_to_ms_valid ? (es_req_sent ? MS_WAIT : MS_READY) : MS_EMPTY;
        else if (w_capture)
            w_state_next = MS_READY;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= MS_EMPTY;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_alu     <= '0;
            r_dest    <= '0;
            r_gr_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_mem_op  <= 3'b000;
            r_hold    <= '0;
        end else begin
            if (w_accept) begin
                r_pc      <= es_pc;
                r_alu     <= es_alu_result;
                r_dest    <= es_dest;
                r_gr_we   <= es_gr_we;
                r_is_load <= es_is_load;
                r_mem_op  <= es_mem_op;
            end
            if (w_capture)
                r_hold <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_discard <= '0;
        end else begin
            assert (!(w_disc_inc && !w_disc_dec && (r_discard == DISC_MAX)))
                else $error("orphan-response counter overflow");
            if (w_disc_inc && !w_disc_dec && (r_discard != DISC_MAX))
                r_discard <= r_discard + 1'b1;
            else if (!w_disc_inc && w_disc_dec)
                r_discard <= r_discard - 1'b1;
        end
    end

    // In WAIT the live response is used the same cycle; in READY the held copy is used.
    assign w_load_src = (r_state == MS_WAIT) ? data_sram_rdata : r_hold;

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (w_load_src),
        .i_addr   (r_alu[1:0]),
        .i_mem_op (r_mem_op),
        .o_data   (w_load_data)
    );

    assign ms_final_result = r_is_load ? w_load_data : r_alu;
    assign ms_to_ws_valid  = w_valid && w_ready_go && !flush;
    assign ms_pc           = r_pc;
    assign ms_dest         = r_dest;
    assign ms_gr_we        = r_gr_we;
    assign ms_fwd_valid    = w_valid && r_gr_we && (r_dest != '0);
    assign ms_fwd_pending  = ms_fwd_valid && r_is_load && !w_ready_go;
    assign ms_fwd_dest     = r_dest;
    assign ms_fwd_data     = ms_final_result;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one task per scenario with hand-computed results.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset, flush, es_to_ms_valid, ms_allowin;
    logic [31:0] es_pc, es_alu_result;
    logic [4:0]  es_dest;
    logic        es_gr_we, es_is_load, es_req_sent;
    logic [2:0]  es_mem_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin, ms_to_ws_valid;
    logic [31:0] ms_pc, ms_final_result, ms_fwd_data;
    logic [4:0]  ms_dest, ms_fwd_dest;
    logic        ms_gr_we, ms_fwd_valid, ms_fwd_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset), .flush(flush),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_is_load(es_is_load), .es_req_sent(es_req_sent),
        .es_mem_op(es_mem_op), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_dest(ms_dest),
        .ms_gr_we(ms_gr_we), .ms_final_result(ms_final_result),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_pending(ms_fwd_pending),
        .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        checks++;
    endtask

    task automatic idle();
        flush = 0; es_to_ms_valid = 0; es_pc = 0; es_alu_result = 0; es_dest = 0;
        es_gr_we = 0; es_is_load = 0; es_req_sent = 0; es_mem_op = 3'b000;
        data_sram_data_ok = 0; data_sram_rdata = 0; ws_allowin = 1;
    endtask

    task automatic drive_es(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                            input logic gr_we, input logic is_load, input logic req_sent,
                            input logic [2:0] op);
        es_to_ms_valid = 1; es_pc = pc; es_alu_result = alu; es_dest = dest;
        es_gr_we = gr_we; es_is_load = is_load; es_req_sent = req_sent; es_mem_op = op;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        settle();
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_fwd_valid !== 1'b0 || ms_fwd_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b allowin=%b fwd=%b pend=%b, required 0 1 0 0",
                     ms_to_ws_valid, ms_allowin, ms_fwd_valid, ms_fwd_pending);
        end
        reset = 0;
        $display("reset: valid=%b allowin=%b", ms_to_ws_valid, ms_allowin);
    endtask

    task automatic test_alu();
        step();
        drive_es(32'h100, 32'h12345678, 5'd3, 1, 0, 0, 3'b000);
        settle();
        if (ms_allowin !== 1'b1) begin
            errors++; $display("FAIL alu_allowin_empty: got %b required 1", ms_allowin);
        end
        step();
        idle();
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h12345678 || ms_dest !== 5'd3 ||
            ms_pc !== 32'h100 || ms_allowin !== 1'b1 || ms_fwd_valid !== 1'b1 || ms_fwd_pending !== 1'b0) begin
            errors++;
            $display("FAIL alu_result: valid=%b res=%h dest=%0d pc=%h allowin=%b fwd=%b pend=%b, required 1 12345678 3 00000100 1 1 0",
                     ms_to_ws_valid, ms_final_result, ms_dest, ms_pc, ms_allowin, ms_fwd_valid, ms_fwd_pending);
        end
        $display("alu: result=%h", ms_final_result);
        step();
        settle();
        if (ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL alu_drain: valid=%b required 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_load_latency(input logic [2:0] op, input logic [31:0] exp);
        int pend_cycles;
        pend_cycles = 0;
        step();
        drive_es(32'h200, 32'h00001002, 5'd5, 1, 1, 1, op);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ms_fwd_pending === 1'b1 && ms_to_ws_valid === 1'b0 && ms_allowin === 1'b0)
                pend_cycles++;
            step();
        end
        checks++;
        if (pend_cycles != 3) begin
            errors++; $display("FAIL load_wait_pending op=%b: pending cycles=%0d required 3", op, pend_cycles);
        end
        data_sram_data_ok = 1; data_sram_rdata = 32'h80FF1234;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== exp || ms_fwd_pending !== 1'b0 || ms_fwd_data !== exp) begin
            errors++;
            $display("FAIL load_result op=%b: valid=%b res=%h pend=%b, required 1 %h 0",
                     op, ms_to_ws_valid, ms_final_result, ms_fwd_pending, exp);
        end
        $display("load op=%b: result=%h", op, ms_final_result);
        step();
        idle();
        settle();
        if (ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL load_drain op=%b: valid=%b required 0", op, ms_to_ws_valid);
        end
    endtask

    task automatic test_backpressure();
        step();
        drive_es(32'h300, 32'h00002002, 5'd6, 1, 1, 1, 3'b001);
        step();
        idle();
        ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h8001ABCD;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hFFFF8001 || ms_allowin !== 1'b0) begin
            errors++;
            $display("FAIL bp_same_cycle: valid=%b res=%h allowin=%b, required 1 ffff8001 0",
                     ms_to_ws_valid, ms_final_result, ms_allowin);
        end
        step();
        data_sram_data_ok = 0; data_sram_rdata = 32'h1234DEAD;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hFFFF8001 || ms_allowin !== 1'b0) begin
            errors++;
            $display("FAIL bp_held: valid=%b res=%h allowin=%b, required 1 ffff8001 0",
                     ms_to_ws_valid, ms_final_result, ms_allowin);
        end
        step();
        ws_allowin = 1; data_sram_rdata = 32'h00000000;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hFFFF8001 || ms_allowin !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b res=%h allowin=%b, required 1 ffff8001 1",
                     ms_to_ws_valid, ms_final_result, ms_allowin);
        end
        $display("backpressure LH: result=%h", ms_final_result);
        step();
        idle();
        settle();
        if (ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: valid=%b required 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_flush_discard();
        // Flush while waiting: one orphan response must be dropped.
        step();
        drive_es(32'h400, 32'h00003000, 5'd6, 1, 1, 1, 3'b000);
        step();
        idle();
        flush = 1;
        settle();
        if (ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL flush_cycle_valid: got %b required 0", ms_to_ws_valid);
        end
        step();
        flush = 0;
        drive_es(32'h404, 32'h00003004, 5'd7, 1, 1, 1, 3'b000);
        settle();
        if (ms_allowin !== 1'b1 || ms_fwd_valid !== 1'b0) begin
            errors++; $display("FAIL flush_emptied: allowin=%b fwd=%b required 1 0", ms_allowin, ms_fwd_valid);
        end
        step();
        idle();
        data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA0000;
        settle();
        if (ms_to_ws_valid !== 1'b0 || ms_fwd_pending !== 1'b1) begin
            errors++; $display("FAIL orphan_dropped: valid=%b pend=%b required 0 1", ms_to_ws_valid, ms_fwd_pending);
        end
        step();
        data_sram_rdata = 32'h5555BEEF;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h5555BEEF || ms_dest !== 5'd7) begin
            errors++;
            $display("FAIL after_orphan: valid=%b res=%h dest=%0d required 1 5555beef 7",
                     ms_to_ws_valid, ms_final_result, ms_dest);
        end
        $display("flush-in-wait: result=%h", ms_final_result);
        step();
        idle();
        // Flush coinciding with accepting a sent request.
        step();
        drive_es(32'h408, 32'h00003008, 5'd8, 1, 1, 1, 3'b000);
        flush = 1;
        step();
        flush = 0;
        drive_es(32'h40C, 32'h0000300C, 5'd9, 1, 1, 1, 3'b000);
        settle();
        if (ms_fwd_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            errors++; $display("FAIL flush_accept_killed: fwd=%b allowin=%b required 0 1", ms_fwd_valid, ms_allowin);
        end
        step();
        idle();
        data_sram_data_ok = 1; data_sram_rdata = 32'h11111111;
        settle();
        if (ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL flush_accept_orphan: valid=%b required 0", ms_to_ws_valid);
        end
        step();
        data_sram_rdata = 32'h22222222;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h22222222 || ms_dest !== 5'd9) begin
            errors++;
            $display("FAIL flush_accept_next: valid=%b res=%h dest=%0d required 1 22222222 9",
                     ms_to_ws_valid, ms_final_result, ms_dest);
        end
        $display("flush-on-accept: result=%h", ms_final_result);
        step();
        idle();
    endtask

    task automatic test_reset_mid_wait();
        step();
        drive_es(32'h500, 32'h00006000, 5'd4, 1, 1, 1, 3'b000);
        step();
        idle();
        flush = 1;
        step();
        flush = 0;
        reset = 1;
        step();
        reset = 0;
        drive_es(32'h504, 32'h00006004, 5'd4, 1, 1, 1, 3'b000);
        step();
        idle();
        data_sram_data_ok = 1; data_sram_rdata = 32'hCAFEF00D;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reset_clears_discard: valid=%b res=%h required 1 cafef00d", ms_to_ws_valid, ms_final_result);
        end
        $display("reset-mid-wait: result=%h", ms_final_result);
        step();
        idle();
    endtask

    task automatic test_store();
        step();
        drive_es(32'h600, 32'h00004000, 5'd9, 0, 0, 1, 3'b000);
        step();
        idle();
        settle();
        if (ms_to_ws_valid !== 1'b0 || ms_gr_we !== 1'b0 || ms_fwd_valid !== 1'b0 || ms_allowin !== 1'b0) begin
            errors++;
            $display("FAIL store_wait: valid=%b we=%b fwd=%b allowin=%b required 0 0 0 0",
                     ms_to_ws_valid, ms_gr_we, ms_fwd_valid, ms_allowin);
        end
        step();
        data_sram_data_ok = 1; data_sram_rdata = 32'hFFFFFFFF;
        settle();
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h00004000 || ms_pc !== 32'h600) begin
            errors++;
            $display("FAIL store_ack: valid=%b res=%h pc=%h required 1 00004000 00000600",
                     ms_to_ws_valid, ms_final_result, ms_pc);
        end
        $display("store: result=%h", ms_final_result);
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [4];
        rd[0] = 32'h01020304; rd[1] = 32'hA5A5A5A5; rd[2] = 32'h0BADF00D; rd[3] = 32'h7FFFFFFF;
        step();
        drive_es(32'h700, 32'h00005000, 5'd10, 1, 1, 1, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) drive_es(32'h700 + 32'(4*k), 32'h00005000 + 32'(4*k), 5'(10+k), 1, 1, 1, 3'b000);
            else       es_to_ms_valid = 0;
            data_sram_data_ok = 1; data_sram_rdata = rd[k-1];
            settle();
            if (ms_to_ws_valid !== 1'b1 || ms_final_result !== rd[k-1] || ms_dest !== 5'(9+k) || ms_allowin !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%b res=%h dest=%0d allowin=%b required 1 %h %0d 1",
                         k, ms_to_ws_valid, ms_final_result, ms_dest, ms_allowin, rd[k-1], 9+k);
            end
            $display("b2b load %0d: result=%h", k, ms_final_result);
        end
        step();
        idle();
        settle();
        if (ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: valid=%b required 0", ms_to_ws_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_latency(3'b010, 32'hFFFFFFFF);
        test_load_latency(3'b110, 32'h000000FF);
        test_backpressure();
        test_flush_discard();
        test_reset_mid_wait();
        test_store();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
